pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register; generic successor to the fixed E/M, D/E and M/W stage registers.
- Carries instruction, PC, payload, destination register, Tnew, exception code and branch-delay flag between any two stages.
- Adds valid/ready back-pressure, flush-to-bubble, first-wins exception merge with writeback kill, and Tnew ageing while an entry is held.
- Instantiated once per stage boundary of the CPU pipeline.

Parameters:
DATA_W, 32, payload width (ALU result, store data, etc. concatenated by the instantiating stage)
DST_W, 5, destination register index width
TNEW_W, 3, Tnew counter width
EXC_W, 7, exception code width (ExCode[8:2] encoding; 0 = no exception)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
flush_i  in  1  discard all held and incoming entries at next edge
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
in_data  in  DATA_W  payload
in_dst  in  DST_W  destination register (0 = none)
in_tnew  in  TNEW_W  cycles until result ready, seen by upstream stage
in_exc  in  EXC_W  exception code from earlier stages
in_bd  in  1  instruction is in a branch delay slot
stage_exc_i  in  EXC_W  exception detected by the upstream stage this cycle
out_valid  out  1  entry present for downstream
out_ready  in  1  downstream accepts
out_instr, out_pc, out_data, out_dst, out_tnew, out_exc, out_bd  out  (widths as inputs)  registered entry

Behaviour:
- Accept = in_valid & in_ready; drain = out_valid & out_ready. All outputs are registered; latency 1 cycle from accept to out_valid.
- Reset (reset==0 at edge): out_valid=0, every out_* field=0 (out_instr=0 is NOP), out_tnew=0. in_ready=0 while reset is low, 1 in the first cycle after release.
- Empty stage: out_valid=0; all out_* fields read 0, so a bubble is a NOP with dst 0, Tnew 0, no exception.
- Capture on accept:
  - out_tnew = in_tnew-1, saturating at 0.
  - out_exc = in_exc if in_exc!=0, else stage_exc_i (earliest exception wins).
  - If the merged exc!=0: out_dst=0 and out_tnew=0 (writeback killed); instr, pc and bd are kept for EPC/BD.
- Hold (out_valid & ~out_ready): all fields stable except out_tnew, which decrements by 1 per held cycle, saturating at 0.
- in_ready (base build) = ~out_valid | out_ready (combinational); accept and drain in the same cycle replaces the entry with no bubble.
- Flush: at the next edge out_valid=0 and all fields are zeroed. An accept in the same cycle is consumed and dropped; flush has priority over accept, hold and drain. in_ready is forced to 1 while flush_i=1 so upstream drains.
- Reset has priority over flush. Reset mid-stall discards the held entry.
- Order is strictly FIFO; no entry is duplicated or lost except by flush or reset.

Optional Feature:
PIPE_SKID_EN:
- Defined: two-entry skid buffer (main + skid). in_ready is registered and equals "skid empty", with no combinational path from out_ready. An accept while main is held goes to skid. On drain, skid moves to main in the same edge. Skid ages Tnew identically to main. Flush and reset clear both entries.
- Not defined: single entry, combinational in_ready as above.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0. After release, in_ready=1.
- Streaming: out_ready=1, present PCs 0x3000, 0x3004, 0x3008 on consecutive cycles with in_tnew=2 -> same PCs appear 1 cycle later, back-to-back, out_tnew=1.
- Stall ageing: capture in_tnew=3, then out_ready=0 for 4 cycles -> out_tnew sequence 2,1,0,0; other fields unchanged. With PIPE_SKID_EN, a second entry sent during the stall is delivered right after the first once out_ready=1.
- Exception merge: in_exc=0, stage_exc_i=7'h0C, in_dst=5'd8 -> out_exc=0x0C, out_dst=0, out_tnew=0. With in_exc=0x04 and stage_exc_i=0x0C -> out_exc=0x04.
- Flush with accept: out_valid=1, in_valid=1, flush_i=1 in the same cycle -> next cycle out_valid=0, out_instr=0, out_dst=0; the dropped entry never appears.
- Reset priority: reset=0 and flush_i=1 together during a stall -> all cleared. The first accept after release propagates normally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, first-wins exception merge and Tnew ageing.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 5,
    parameter int TNEW_W = 3,
    parameter int EXC_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DST_W-1:0]  in_dst,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  stage_exc_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [DST_W-1:0]  out_dst,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
        logic [DST_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } entry_t;

    localparam logic [TNEW_W-1:0] ONE_T = TNEW_W'(1);

    function automatic entry_t age(input entry_t e);
        entry_t a;
        a = e;
        if (a.tnew != '0) a.tnew = a.tnew - ONE_T;
        return a;
    endfunction

    logic [EXC_W-1:0] w_exc;
    entry_t           w_cap;
    logic             w_acc;
    logic             w_drn;
    logic             r_valid;
    entry_t           r_main;

    // An exception raised earlier in the pipe outranks one raised by this stage.
    assign w_exc = (in_exc != '0) ? in_exc : stage_exc_i;

    always_comb begin
        w_cap       = '0;
        w_cap.instr = in_instr;
        w_cap.pc    = in_pc;
        w_cap.data  = in_data;
        w_cap.bd    = in_bd;
        w_cap.exc   = w_exc;
        w_cap.dst   = (w_exc != '0) ? '0 : in_dst;
        w_cap.tnew  = (w_exc != '0 || in_tnew == '0) ? '0 : in_tnew - ONE_T;
    end

    assign w_acc = in_valid & in_ready;
    assign w_drn = r_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic   r_skid_vld;
    entry_t r_skid;

    assign in_ready = reset & (flush_i | ~r_skid_vld);

    // Skid is only ever occupied while main is occupied.
    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            r_valid    <= 1'b0;
            r_main     <= '0;
            r_skid_vld <= 1'b0;
            r_skid     <= '0;
        end else if (!r_valid) begin
            r_valid <= w_acc;
            r_main  <= w_acc ? w_cap : '0;
        end else if (w_drn) begin
            if (r_skid_vld) begin
                r_main     <= age(r_skid);
                r_skid_vld <= 1'b0;
                r_skid     <= '0;
            end else if (w_acc) begin
                r_main <= w_cap;
            end else begin
                r_valid <= 1'b0;
                r_main  <= '0;
            end
        end else begin
            r_main <= age(r_main);
            if (w_acc) begin
                r_skid_vld <= 1'b1;
                r_skid     <= w_cap;
            end else if (r_skid_vld) begin
                r_skid <= age(r_skid);
            end
        end
    end
`else
    assign in_ready = reset & (flush_i | ~r_valid | out_ready);

    always_ff @(posedge clk) begin
        if (!reset || flush_i) begin
            r_valid <= 1'b0;
            r_main  <= '0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_main  <= w_cap;
        end else if (w_drn) begin
            r_valid <= 1'b0;
            r_main  <= '0;
        end else if (r_valid) begin
            r_main <= age(r_main);
        end
    end
`endif

    assign out_valid = r_valid;
    assign out_instr = r_main.instr;
    assign out_pc    = r_main.pc;
    assign out_data  = r_main.data;
    assign out_dst   = r_main.dst;
    assign out_tnew  = r_main.tnew;
    assign out_exc   = r_main.exc;
    assign out_bd    = r_main.bd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: scenario tasks plus a scoreboard monitor on the falling edge.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset, flush_i, in_valid, in_ready, in_bd, out_valid, out_ready, out_bd;
    logic [31:0] in_instr, in_pc, in_data, out_instr, out_pc, out_data;
    logic [4:0]  in_dst, out_dst;
    logic [2:0]  in_tnew, out_tnew;
    logic [6:0]  in_exc, stage_exc_i, out_exc;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] instr, pc, data;
        logic [4:0]  dst;
        int          tnew;
        logic [6:0]  exc;
        logic        bd;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t me;
    int   mt;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data), .in_dst(in_dst),
        .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd), .stage_exc_i(stage_exc_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data), .out_dst(out_dst),
        .out_tnew(out_tnew), .out_exc(out_exc), .out_bd(out_bd)
    );

    // Scoreboard: compare the presented entry, then account for the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            tests++;
            if (sb.size() == 0) begin
                if (out_valid !== 1'b0 || out_instr !== 0 || out_pc !== 0 || out_data !== 0 ||
                    out_dst !== 0 || out_tnew !== 0 || out_exc !== 0 || out_bd !== 1'b0) begin
                    fails++;
                    $display("FAIL sb_bubble: got v=%b instr=%h pc=%h data=%h dst=%0d tnew=%0d exc=%h bd=%b, exp all zero",
                             out_valid, out_instr, out_pc, out_data, out_dst, out_tnew, out_exc, out_bd);
                end
            end else begin
                me = sb[0];
                mt = me.tnew - (cyc - me.cyc - 1);
                if (mt < 0) mt = 0;
                if (out_valid !== 1'b1 || out_instr !== me.instr || out_pc !== me.pc || out_data !== me.data ||
                    out_dst !== me.dst || out_tnew !== mt[2:0] || out_exc !== me.exc || out_bd !== me.bd) begin
                    fails++;
                    $display("FAIL sb_entry: got v=%b pc=%h instr=%h dst=%0d tnew=%0d exc=%h bd=%b, exp v=1 pc=%h instr=%h dst=%0d tnew=%0d exc=%h bd=%b",
                             out_valid, out_pc, out_instr, out_dst, out_tnew, out_exc, out_bd,
                             me.pc, me.instr, me.dst, mt, me.exc, me.bd);
                end
            end
            if (reset !== 1'b1 || flush_i === 1'b1) begin
                sb.delete();
            end else begin
                if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() > 0) void'(sb.pop_front());
                if (in_valid === 1'b1 && in_ready === 1'b1) begin
                    me.instr = in_instr; me.pc = in_pc; me.data = in_data; me.bd = in_bd;
                    me.exc   = (in_exc != 0) ? in_exc : stage_exc_i;
                    me.dst   = (me.exc != 0) ? 5'd0 : in_dst;
                    me.tnew  = (me.exc != 0 || in_tnew == 0) ? 0 : int'(in_tnew) - 1;
                    me.cyc   = cyc;
                    sb.push_back(me);
                end
            end
        end
    end

    task automatic set_in(input logic [31:0] pc, input logic [4:0] dst, input logic [2:0] tnew,
                          input logic [6:0] exc, input logic [6:0] sexc, input logic bd);
        in_valid = 1'b1; in_pc = pc; in_instr = pc ^ 32'h2400_0000; in_data = ~pc;
        in_dst = dst; in_tnew = tnew; in_exc = exc; stage_exc_i = sexc; in_bd = bd;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
        set_in(32'h1000, 5'd4, 3'd2, 7'd0, 7'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || out_instr !== 0 || out_pc !== 0 || out_dst !== 0 ||
                out_tnew !== 0 || out_exc !== 0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: got v=%b instr=%h pc=%h dst=%0d tnew=%0d exc=%h in_ready=%b, exp all 0",
                         out_valid, out_instr, out_pc, out_dst, out_tnew, out_exc, in_ready);
            end
        end
        next_cycle();
        reset = 1'b1; in_valid = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i < 3) set_in(32'h3000 + 32'(4 * i), 5'(i + 1), 3'd2, 7'd0, 7'd0, i[0]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * (i - 1)) || out_tnew !== 3'd1) begin
                    fails++;
                    $display("FAIL stream_%0d: got v=%b pc=%h tnew=%0d, exp v=1 pc=%h tnew=1",
                             i, out_valid, out_pc, out_tnew, 32'h3000 + 32'(4 * (i - 1)));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_t [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
        bit sent, found;
        int when;
        next_cycle();
        out_ready = 1'b1;
        set_in(32'h4000, 5'd9, 3'd3, 7'd0, 7'd0, 1'b1);
        next_cycle();
        out_ready = 1'b0;
        set_in(32'h4004, 5'd10, 3'd3, 7'd0, 7'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_tnew !== exp_t[k] || out_pc !== 32'h4000 || out_dst !== 5'd9 || out_bd !== 1'b1) begin
                fails++;
                $display("FAIL stall_age_%0d: got v=%b tnew=%0d pc=%h dst=%0d bd=%b, exp v=1 tnew=%0d pc=4000 dst=9 bd=1",
                         k, out_valid, out_tnew, out_pc, out_dst, out_bd, exp_t[k]);
            end
            sent = in_valid && in_ready;
            next_cycle();
            if (sent) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        found = 1'b0; when = -1;
        for (int j = 0; j < 6 && !found; j++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_pc === 32'h4004) begin found = 1'b1; when = j; end
            sent = in_valid && in_ready;
            next_cycle();
            if (sent) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        tests++;
        if (!found || when != 1) begin
            fails++;
            $display("FAIL stall_second: got found=%b at cycle %0d, exp delivered at cycle 1", found, when);
        end
    endtask

    task automatic test_exc();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 0) set_in(32'h7000, 5'd8, 3'd3, 7'h00, 7'h0C, 1'b1);
            else if (i == 1) set_in(32'h7004, 5'd3, 3'd2, 7'h04, 7'h0C, 1'b0);
            else begin in_valid = 1'b0; in_exc = 0; stage_exc_i = 0; end
            @(negedge clk);
            if (i == 1) begin
                tests++;
                if (out_exc !== 7'h0C || out_dst !== 5'd0 || out_tnew !== 3'd0 || out_pc !== 32'h7000 || out_bd !== 1'b1) begin
                    fails++;
                    $display("FAIL exc_stage: got exc=%h dst=%0d tnew=%0d pc=%h bd=%b, exp exc=0c dst=0 tnew=0 pc=7000 bd=1",
                             out_exc, out_dst, out_tnew, out_pc, out_bd);
                end
            end else if (i == 2) begin
                tests++;
                if (out_exc !== 7'h04 || out_dst !== 5'd0 || out_pc !== 32'h7004) begin
                    fails++;
                    $display("FAIL exc_first_wins: got exc=%h dst=%0d pc=%h, exp exc=04 dst=0 pc=7004",
                             out_exc, out_dst, out_pc);
                end
            end
        end
    endtask

    task automatic test_flush();
        next_cycle();
        out_ready = 1'b0;
        set_in(32'h5000, 5'd6, 3'd1, 7'd0, 7'd0, 1'b0);
        next_cycle();
        set_in(32'h5004, 5'd7, 3'd1, 7'd0, 7'd0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_ready: got in_ready=%b out_valid=%b, exp 1 1", in_ready, out_valid);
        end
        next_cycle();
        flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_instr !== 0 || out_dst !== 0) begin
            fails++;
            $display("FAIL flush_clear: got v=%b instr=%h dst=%0d, exp 0 0 0", out_valid, out_instr, out_dst);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || out_pc === 32'h5004) begin
                fails++;
                $display("FAIL flush_dropped_%0d: got v=%b pc=%h, exp v=0", k, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_reset_prio();
        next_cycle();
        out_ready = 1'b0;
        set_in(32'h6000, 5'd12, 3'd2, 7'd0, 7'd0, 1'b0);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        reset = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_pc !== 32'h6000) begin
            fails++;
            $display("FAIL rprio_held: got in_ready=%b pc=%h, exp 0 6000", in_ready, out_pc);
        end
        next_cycle();
        reset = 1'b1; flush_i = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_pc !== 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rprio_clear: got v=%b pc=%h in_ready=%b, exp 0 0 1", out_valid, out_pc, in_ready);
        end
        next_cycle();
        out_ready = 1'b1;
        set_in(32'h6004, 5'd13, 3'd2, 7'd0, 7'd0, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h6004 || out_tnew !== 3'd1 || out_dst !== 5'd13) begin
            fails++;
            $display("FAIL rprio_after: got v=%b pc=%h tnew=%0d dst=%0d, exp 1 6004 1 13",
                     out_valid, out_pc, out_tnew, out_dst);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_instr = 0; in_pc = 0; in_data = 0; in_dst = 0;
        in_tnew = 0; in_exc = 0; in_bd = 1'b0; stage_exc_i = 0;
        test_reset();
        test_stream();
        test_stall();
        test_exc();
        test_flush();
        test_reset_prio();
        repeat (3) next_cycle();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drained: got %0d entries outstanding, exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
